// File: rtl/rowbias_server.sv
// rtl/rowbias_server.sv - per-row 1-hot bias table server with optional LFSR Fisher-Yates reshuffle.
// Define ROWBIAS_SHUFFLE_EN to enable the shuffle FSM; otherwise the table is a fixed identity.
module rowbias_server #(
  parameter int          LEN  = 9,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [LEN:0]   rqindex,
  input  logic           updaterowbias,
  output logic [LEN-1:0] rowbias,
  input  logic           shuffle,
  input  logic           reseed,
  input  logic [15:0]    seed,
  output logic           busy,
  output logic           rq_err
);

  localparam int W = (LEN > 1) ? $clog2(LEN) : 1;

  logic [LEN-1:0] bias [LEN];

`ifdef ROWBIAS_SHUFFLE_EN
  typedef enum logic [1:0] {FILL, SHUF, READY} state_t;

  localparam logic [W-1:0] LAST = W'(LEN - 1);

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [W-1:0] idx;
  logic [W-1:0] cand;
  logic [2:0]  retries;

  // Galois form, taps 16,14,13,11
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign cand      = lfsr[W-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= FILL;
      busy    <= 1'b1;
      lfsr    <= SEED;
      idx     <= LAST;
      retries <= '0;
      for (int k = 0; k < LEN; k++) bias[k] <= LEN'(1) << k;
    end else begin
      lfsr <= (reseed && seed != 16'h0000) ? seed : lfsr_next;
      case (state)
        FILL: begin
          for (int k = 0; k < LEN; k++) bias[k] <= LEN'(1) << k;
          retries <= '0;
          state   <= SHUF;
        end
        SHUF: begin
          // the 8th try at one index is forced so a full pass is bounded
          if (cand <= idx || retries == 3'd7) begin
            if (cand <= idx) begin
              bias[idx]  <= bias[cand];
              bias[cand] <= bias[idx];
            end
            retries <= '0;
            idx     <= idx - W'(1);
            if (idx == W'(1)) begin
              state <= READY;
              busy  <= 1'b0;
            end
          end else begin
            retries <= retries + 3'd1;
          end
        end
        READY: begin
          if (shuffle) begin
            idx   <= LAST;
            state <= FILL;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= FILL;
          busy  <= 1'b1;
        end
      endcase
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{shuffle, reseed, seed, SEED};
  assign busy       = 1'b0;

  always_comb begin
    for (int k = 0; k < LEN; k++) bias[k] = LEN'(1) << k;
  end
`endif

  logic           is_onehot;
  logic [LEN-1:0] pick;

  always_comb begin
    is_onehot = (rqindex != '0) &&
                ((rqindex & (rqindex - {{LEN{1'b0}}, 1'b1})) == '0);
    pick = '0;
    for (int k = 0; k < LEN; k++) begin
      if (rqindex[k]) pick = pick | bias[k];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rowbias <= '0;
      rq_err  <= 1'b0;
    end else if (updaterowbias) begin
      if (busy || !is_onehot) begin
        rowbias <= '0;
        rq_err  <= 1'b1;
      end else if (rqindex[LEN]) begin
        rowbias <= '0;
      end else begin
        rowbias <= pick;
      end
    end
  end

endmodule

// File: tb/tb_rowbias_server.sv
// tb/tb_rowbias_server.sv - self-checking bench for rowbias_server (identity or ROWBIAS_SHUFFLE_EN build).
module tb_rowbias_server;

  localparam int LEN = 9;
`ifdef ROWBIAS_SHUFFLE_EN
  localparam bit SHUF_EN = 1'b1;
`else
  localparam bit SHUF_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [LEN:0]   rqindex = '0;
  logic           updaterowbias = 1'b0;
  logic           shuffle = 1'b0;
  logic           reseed = 1'b0;
  logic [15:0]    seed = 16'h0000;
  logic [LEN-1:0] rowbias;
  logic           busy;
  logic           rq_err;

  int checks = 0;
  int errors = 0;
  logic           model_err = 1'b0;
  logic [LEN-1:0] exp_row = '0;

  rowbias_server #(.LEN(LEN), .SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset), .rqindex(rqindex), .updaterowbias(updaterowbias),
    .rowbias(rowbias), .shuffle(shuffle), .reseed(reseed), .seed(seed),
    .busy(busy), .rq_err(rq_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input logic [LEN:0] q);
    rqindex = q;
    updaterowbias = 1'b1;
    tick();
    updaterowbias = 1'b0;
  endtask

  // Reference: identity table, sentinel gives zero, anything not 1-hot is an error
  function automatic logic [LEN-1:0] model_reply(input logic [LEN:0] q);
    if ($countones(q) != 1 || q[LEN]) return '0;
    return q[LEN-1:0];
  endfunction

  function automatic logic model_bad(input logic [LEN:0] q);
    return $countones(q) != 1;
  endfunction

  function automatic logic [LEN:0] rand_query(input int allow_bad);
    int kind;
    int a;
    int b;
    logic [LEN:0] q;
    kind = allow_bad ? $urandom_range(0, 11) : $urandom_range(0, 8);
    a = $urandom_range(0, LEN);
    b = (a + 1 + $urandom_range(0, LEN - 1)) % (LEN + 1);
    q = '0;
    if (kind < 7)       q[$urandom_range(0, LEN - 1)] = 1'b1;
    else if (kind < 9)  q[LEN] = 1'b1;
    else if (kind < 11) begin q[a] = 1'b1; q[b] = 1'b1; end
    return q;
  endfunction

  task automatic model_request(input string tag, input logic [LEN:0] q);
    exp_row = model_reply(q);
    model_err = model_err | model_bad(q);
    request(q);
    chk(tag, rowbias, exp_row);
    chk({tag, "_err"}, rq_err, model_err);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk({tag, "_hold"}, rowbias, exp_row);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 80) begin
      tick();
      n++;
    end
    chk(tag, (busy === 1'b0 && n <= 65), 1);
  endtask

  task automatic read_table(output logic [LEN-1:0] t [LEN]);
    for (int k = 0; k < LEN; k++) begin
      request((LEN + 1)'(1) << k);
      t[k] = rowbias;
    end
  endtask

  task automatic check_perm(input string tag, input logic [LEN-1:0] t [LEN]);
    logic [LEN-1:0] acc;
    int good;
    acc = '0;
    good = 1;
    for (int k = 0; k < LEN; k++) begin
      acc = acc | t[k];
      if ($countones(t[k]) != 1) good = 0;
    end
    chk({tag, "_onehot"}, good, 1);
    chk({tag, "_or"}, acc, {LEN{1'b1}});
  endtask

  initial begin
    logic [LEN-1:0] ta [LEN];
    logic [LEN-1:0] tb [LEN];
    int same;

    #2 reset = 1'b0;
    #1;
    chk("rst_rowbias", rowbias, 0);
    chk("rst_err", rq_err, 0);
    chk("rst_busy", busy, SHUF_EN);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;

`ifndef ROWBIAS_SHUFFLE_EN
    model_request("idx2", 10'b0000000100);
    model_request("sentinel", 10'b1000000000);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("sentinel_hold", rowbias, 0);
    end
    for (int n = 0; n < 25; n++) model_request("rand_ok", rand_query(0));
    model_request("malformed", 10'b0000000011);
    chk("malformed_err", rq_err, 1);
    model_request("zero_q", 10'b0000000000);
    for (int n = 0; n < 30; n++) model_request("rand_any", rand_query(1));

    seed = 16'h1234;
    reseed = 1'b1;
    shuffle = 1'b1;
    tick();
    reseed = 1'b0;
    shuffle = 1'b0;
    chk("ign_busy", busy, 0);
    model_request("after_shuf", 10'b0100000000);
`else
    wait_ready("boot_ready");
    read_table(ta);
    check_perm("boot", ta);
    chk("boot_err", rq_err, 0);

    seed = 16'h1234;
    reseed = 1'b1;
    shuffle = 1'b1;
    tick();
    reseed = 1'b0;
    shuffle = 1'b0;
    wait_ready("shuf1_ready");
    read_table(ta);
    check_perm("shuf1", ta);

    reseed = 1'b1;
    shuffle = 1'b1;
    tick();
    reseed = 1'b0;
    shuffle = 1'b0;
    wait_ready("shuf2_ready");
    read_table(tb);
    check_perm("shuf2", tb);
    same = 1;
    for (int k = 0; k < LEN; k++) if (ta[k] !== tb[k]) same = 0;
    chk("reseed_repeat", same, 1);

    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    request(10'b0000000001);
    chk("busy_drop", rowbias, 0);
    chk("busy_drop_err", rq_err, 1);
    wait_ready("drop_ready");

    read_table(ta);
    shuffle = 1'b1;
    rqindex = 10'b0000000001;
    updaterowbias = 1'b1;
    tick();
    shuffle = 1'b0;
    updaterowbias = 1'b0;
    chk("same_cycle_old", rowbias, ta[0]);
    chk("same_cycle_busy", busy, 1);

    repeat (4) tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_row", rowbias, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_err", rq_err, 0);
    tick();
    reset = 1'b1;
    wait_ready("mid_ready");
    read_table(ta);
    check_perm("mid", ta);
    chk("mid_err", rq_err, 0);
`endif

    reset = 1'b0;
    #1;
    chk("final_rst_err", rq_err, 0);
    chk("final_rst_row", rowbias, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
